// File: rtl/register_file.sv
// register_file: 32x32 MIPS register file with two asynchronous read ports,
// a falling-edge write port, and integrated write-destination / write-back muxes.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  RegDst,
    input  logic                  RegWre,
    input  logic                  DBDataSrc,
    input  logic [ADDR_WIDTH-1:0] rs,
    input  logic [ADDR_WIDTH-1:0] rt,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0] dataFromALU,
    input  logic [DATA_WIDTH-1:0] dataFromRW,
    output logic [DATA_WIDTH-1:0] Data1,
    output logic [DATA_WIDTH-1:0] Data2,
    output logic [DATA_WIDTH-1:0] writeData
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [DEPTH];
    logic [ADDR_WIDTH-1:0] w_write_reg;

    always_comb begin
        w_write_reg = RegDst ? rd : rt;
        writeData   = DBDataSrc ? dataFromRW : dataFromALU;
        Data1       = (rs == '0) ? '0 : r_regs[rs];
        Data2       = (rt == '0) ? '0 : r_regs[rt];
    end

    // Commit mid-cycle so the rising-edge PC update and datapath settle first.
    always_ff @(negedge CLK or negedge Reset) begin
        if (!Reset)
            r_regs <= '{default: '0};
        else if (RegWre && w_write_reg != '0)
            r_regs[w_write_reg] <= writeData;
    end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed vectors with hand-computed expectations for register_file.
module tb_register_file;
    logic        CLK = 1'b0;
    logic        Reset;
    logic        RegDst;
    logic        RegWre;
    logic        DBDataSrc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] dataFromALU;
    logic [31:0] dataFromRW;
    logic [31:0] Data1;
    logic [31:0] Data2;
    logic [31:0] writeData;

    int vecs = 0;
    int errs = 0;

    register_file dut (
        .CLK(CLK), .Reset(Reset), .RegDst(RegDst), .RegWre(RegWre),
        .DBDataSrc(DBDataSrc), .rs(rs), .rt(rt), .rd(rd),
        .dataFromALU(dataFromALU), .dataFromRW(dataFromRW),
        .Data1(Data1), .Data2(Data2), .writeData(writeData)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic after_fall();
        @(negedge CLK);
        #1;
    endtask

    task automatic after_rise();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b0; RegDst = 1'b0; RegWre = 1'b1; DBDataSrc = 1'b0;
        rs = 5'd0; rt = 5'd1; rd = 5'd0;
        dataFromALU = 32'hDEAD_BEEF; dataFromRW = 32'h0;
        after_fall();
        after_fall();
        check("rst_d1_r0", Data1, 32'h0);
        check("rst_d2_r1", Data2, 32'h0);
        rs = 5'd2; rt = 5'd31; #1;
        check("rst_d1_r2", Data1, 32'h0);
        check("rst_d2_r31", Data2, 32'h0);
        check("rst_wdata_comb", writeData, 32'hDEAD_BEEF);
        RegWre = 1'b0;
        after_rise();
        Reset = 1'b1;
        after_fall();
        check("post_rst_d1_r2", Data1, 32'h0);
        check("post_rst_d2_r31", Data2, 32'h0);

        // R-type ALU write to reg2
        RegDst = 1'b1; RegWre = 1'b1; DBDataSrc = 1'b0;
        rs = 5'd0; rt = 5'd1; rd = 5'd2;
        dataFromALU = 32'd1; dataFromRW = 32'd2; #1;
        check("rtype_wdata", writeData, 32'd1);
        after_fall();
        check("rtype_d1_r0", Data1, 32'h0);
        check("rtype_d2_r1", Data2, 32'h0);
        rs = 5'd2; #1;
        check("rtype_d1_r2", Data1, 32'd1);

        // I-type memory write to reg4 (rt), rd ignored
        RegDst = 1'b0; DBDataSrc = 1'b1;
        rs = 5'd3; rt = 5'd4; rd = 5'd5;
        dataFromALU = 32'd3; dataFromRW = 32'd4; #1;
        check("itype_wdata", writeData, 32'd4);
        after_fall();
        check("itype_d2_r4", Data2, 32'd4);
        check("itype_d1_r3", Data1, 32'h0);
        RegWre = 1'b0; rs = 5'd5; #1;
        check("itype_r5_untouched", Data1, 32'h0);

        // register 0 discards writes
        RegWre = 1'b1; RegDst = 1'b1; DBDataSrc = 1'b0;
        rd = 5'd0; dataFromALU = 32'hFFFF_FFFF;
        after_fall();
        rs = 5'd0; rt = 5'd0; #1;
        check("reg0_d1", Data1, 32'h0);
        check("reg0_d2", Data2, 32'h0);

        // write disabled
        RegWre = 1'b0; rd = 5'd6; dataFromALU = 32'h1234_5678;
        after_fall();
        after_fall();
        after_fall();
        rs = 5'd6; #1;
        check("wdis_r6", Data1, 32'h0);
        check("wdis_wdata", writeData, 32'h1234_5678);

        // edge timing on reg7
        RegWre = 1'b1; rd = 5'd7; dataFromALU = 32'hA5A5_A5A5;
        rs = 5'd7; rt = 5'd7;
        after_rise();
        check("edge_before_fall", Data1, 32'h0);
        after_fall();
        check("edge_after_fall", Data1, 32'hA5A5_A5A5);
        check("edge_rs_eq_rt", Data2, 32'hA5A5_A5A5);
        RegWre = 1'b0;
        after_rise();
        check("edge_rise_nochange", Data1, 32'hA5A5_A5A5);

        // asynchronous reset mid-operation, with a write pending
        rs = 5'd2; #1;
        check("pre_rst_r2", Data1, 32'd1);
        RegWre = 1'b1; rd = 5'd9; dataFromALU = 32'h0BAD_F00D;
        #1 Reset = 1'b0;
        #1;
        check("async_rst_r2", Data1, 32'h0);
        check("async_rst_r7", Data2, 32'h0);
        check("async_rst_wdata", writeData, 32'h0BAD_F00D);
        after_fall();
        rs = 5'd9; #1;
        check("rst_priority_r9", Data1, 32'h0);
        RegWre = 1'b0;
        after_rise();
        Reset = 1'b1;
        after_fall();
        check("after_rerst_r9", Data1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
